// File: rtl/delay_data_pool_if.sv
// Handshake bundle for delay_data_pool: input transaction side, output
// presentation side and the occupancy count.
interface delay_data_pool_if #(
    parameter int width     = 16,
    parameter int tag_width = 4,
    parameter int n_slots   = 4,
    parameter int max_delay = 7
);
    localparam int dw = ($clog2(max_delay + 1) < 1) ? 1 : $clog2(max_delay + 1);
    localparam int cw = $clog2(n_slots + 1);

    logic                 in_vld;
    logic                 in_rdy;
    logic [dw-1:0]        in_delay;
    logic [width-1:0]     in_data;
    logic [tag_width-1:0] in_tag;
    logic                 out_vld;
    logic                 out_rdy;
    logic [width-1:0]     out_data;
    logic [tag_width-1:0] out_tag;
    logic [cw-1:0]        busy_cnt;

    modport master (
        output in_vld, in_delay, in_data, in_tag, out_rdy,
        input  in_rdy, out_vld, out_data, out_tag, busy_cnt
    );

    modport slave (
        input  in_vld, in_delay, in_data, in_tag, out_rdy,
        output in_rdy, out_vld, out_data, out_tag, busy_cnt
    );
endinterface

// File: rtl/delay_data_pool.sv
// Multi-slot delay pool: each accepted transaction waits its own delay, then
// completions leave through a valid/ready port, lowest done slot first.
module delay_data_pool #(
    parameter int width     = 16,
    parameter int tag_width = 4,
    parameter int n_slots   = 4,
    parameter int max_delay = 7
) (
    input  logic             clk,
    input  logic             rst,
    delay_data_pool_if.slave bus
);
    localparam int dw = ($clog2(max_delay + 1) < 1) ? 1 : $clog2(max_delay + 1);
    localparam int cw = $clog2(n_slots + 1);
    localparam int iw = (n_slots > 1) ? $clog2(n_slots) : 1;

    logic [n_slots-1:0]   occ_q, occ_d;
    logic [dw-1:0]        cnt_q  [n_slots];
    logic [dw-1:0]        cnt_d  [n_slots];
    logic [width-1:0]     data_q [n_slots];
    logic [width-1:0]     data_d [n_slots];
    logic [tag_width-1:0] tag_q  [n_slots];
    logic [tag_width-1:0] tag_d  [n_slots];
    logic                 lock_vld_q, lock_vld_d;
    logic [iw-1:0]        lock_idx_q, lock_idx_d;
    logic [cw-1:0]        busy_q, busy_d;

    logic [n_slots-1:0]   done_vec;
    logic [n_slots-1:0]   free_vec;
    logic [iw-1:0]        free_idx;
    logic [iw-1:0]        done_idx;
    logic                 any_free;
    logic                 any_done;
    logic                 sel_vld;
    logic [iw-1:0]        sel_idx;
    logic                 accept;
    logic                 handshake;
    logic [dw-1:0]        delay_clamped;

    for (genvar gi = 0; gi < n_slots; gi++) begin : g_slot
        assign done_vec[gi] = occ_q[gi] && (cnt_q[gi] == '0);
        assign free_vec[gi] = !occ_q[gi];
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        free_idx = '0;
        done_idx = '0;
        for (int i = n_slots - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx = iw'(i);
            if (done_vec[i]) done_idx = iw'(i);
        end
    end

    assign any_free = |free_vec;
    assign any_done = |done_vec;

    // An unlocked pool presents the lowest done slot right away; the lock
    // register then pins it until the handshake completes.
    assign sel_vld   = lock_vld_q || any_done;
    assign sel_idx   = lock_vld_q ? lock_idx_q : done_idx;
    assign accept    = bus.in_vld && any_free;
    assign handshake = sel_vld && bus.out_rdy;

    assign delay_clamped = (bus.in_delay > dw'(max_delay)) ? dw'(max_delay) : bus.in_delay;

    always_comb begin
        occ_d      = occ_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        busy_d     = busy_q;
        for (int i = 0; i < n_slots; i++) begin
            cnt_d[i]  = (occ_q[i] && (cnt_q[i] != '0)) ? cnt_q[i] - 1'b1 : cnt_q[i];
            data_d[i] = data_q[i];
            tag_d[i]  = tag_q[i];
        end

        if (handshake) begin
            occ_d[sel_idx] = 1'b0;
            lock_vld_d     = 1'b0;
        end else if (sel_vld) begin
            lock_vld_d = 1'b1;
            lock_idx_d = sel_idx;
        end

        // free_idx comes from registered occupancy, so a slot freed at this
        // edge can never be the one being refilled.
        if (accept) begin
            occ_d[free_idx]  = 1'b1;
            cnt_d[free_idx]  = delay_clamped;
            data_d[free_idx] = bus.in_data;
            tag_d[free_idx]  = bus.in_tag;
        end

        case ({accept, handshake})
            2'b10:   busy_d = busy_q + 1'b1;
            2'b01:   busy_d = busy_q - 1'b1;
            default: busy_d = busy_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            busy_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            busy_q     <= busy_d;
        end
    end

    // Slot payload and countdown only matter while occupied, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < n_slots; i++) begin
            cnt_q[i]  <= cnt_d[i];
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
        end
    end

    assign bus.in_rdy   = any_free;
    assign bus.out_vld  = sel_vld;
    assign bus.out_data = sel_vld ? data_q[sel_idx] : '0;
    assign bus.out_tag  = sel_vld ? tag_q[sel_idx] : '0;
    assign bus.busy_cnt = busy_q;
endmodule

// File: tb/tb_delay_data_pool.sv
// Scoreboard bench for delay_data_pool: expected outputs (data, tag, cycle)
// are queued as stimulus is accepted and popped on each output handshake.
module tb_delay_data_pool;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_data_pool_if #(.width(16), .tag_width(4), .n_slots(4), .max_delay(7)) bus ();
    delay_data_pool_if #(.width(16), .tag_width(4), .n_slots(4), .max_delay(5)) bus5 ();

    delay_data_pool #(.width(16), .tag_width(4), .n_slots(4), .max_delay(7)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    delay_data_pool #(.width(16), .tag_width(4), .n_slots(4), .max_delay(5)) u_dut5 (
        .clk(clk), .rst(rst), .bus(bus5)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        int          t;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   prev_stall = 1'b0;
    logic [19:0] prev_out = '0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", name, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [3:0] tg, input int t);
        exp_t e;
        int   i;
        e.data = d;
        e.tag  = tg;
        e.t    = t;
        i = 0;
        while (i < sb_q.size() && sb_q[i].t <= t) i++;
        sb_q.insert(i, e);
    endtask

    // Called just after a posedge; returns the edge index that accepted it.
    task automatic send(input logic [15:0] d, input logic [3:0] tg, input logic [2:0] dl,
                        output int acc);
        int n;
        n = 0;
        bus.in_vld   = 1'b1;
        bus.in_data  = d;
        bus.in_tag   = tg;
        bus.in_delay = dl;
        while (bus.in_rdy !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_eq("send_timeout", 32'(n), 0);
        @(posedge clk); #1;
        acc = cyc;
        bus.in_vld = 1'b0;
        $display("send data=%h tag=%0d delay=%0d accepted at edge %0d", d, tg, dl, acc);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb_q.size()), 0);
        @(posedge clk); #1;
    endtask

    // Output monitor on the main instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_vld && bus.out_rdy) begin
                check_eq("sb_has_item", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    $display("recv data=%h tag=%0d cyc=%0d (exp data=%h tag=%0d cyc=%0d)",
                             bus.out_data, bus.out_tag, cyc, mon_e.data, mon_e.tag, mon_e.t);
                    check_eq("out_data", 32'(bus.out_data), 32'(mon_e.data));
                    check_eq("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
                    check_eq("out_cycle", 32'(cyc), 32'(mon_e.t));
                end
            end
            if (!bus.out_vld)
                check_eq("idle_zero", 32'({bus.out_tag, bus.out_data}), 0);
            if (prev_stall) begin
                check_eq("stall_vld", 32'(bus.out_vld), 1);
                check_eq("stall_hold", 32'({bus.out_tag, bus.out_data}), 32'(prev_out));
            end
            check_eq("in_rdy_vs_busy", 32'(bus.in_rdy), 32'(bus.busy_cnt < 4));
            prev_stall = bus.out_vld && !bus.out_rdy && rst;
            prev_out   = {bus.out_tag, bus.out_data};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, a4, e;
        int n;
        rst = 1'b0;
        bus.in_vld = 1'b0;  bus.in_delay = '0;  bus.in_data = '0;  bus.in_tag = '0;
        bus.out_rdy = 1'b0;
        bus5.in_vld = 1'b0; bus5.in_delay = '0; bus5.in_data = '0; bus5.in_tag = '0;
        bus5.out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // 1: reset state, then a single delay-3 transaction
        check_eq("rst_in_rdy", 32'(bus.in_rdy), 1);
        check_eq("rst_out_vld", 32'(bus.out_vld), 0);
        check_eq("rst_out_data", 32'(bus.out_data), 0);
        check_eq("rst_out_tag", 32'(bus.out_tag), 0);
        check_eq("rst_busy", 32'(bus.busy_cnt), 0);
        bus.out_rdy = 1'b1;
        send(16'hABCD, 4'd5, 3'd3, a0);
        push_exp(16'hABCD, 4'd5, a0 + 3);
        check_eq("t1_busy_one", 32'(bus.busy_cnt), 1);
        drain(30);
        check_eq("t1_busy_zero", 32'(bus.busy_cnt), 0);

        // 2: out-of-order completion
        send(16'h1111, 4'd1, 3'd6, a0);
        push_exp(16'h1111, 4'd1, a0 + 6);
        send(16'h2222, 4'd2, 3'd0, a1);
        push_exp(16'h2222, 4'd2, a1);
        check_eq("t2_b_after_a", 32'(a1 - a0), 1);
        drain(30);

        // 3: fill the pool, fifth waits for the first handshake
        send(16'h3000, 4'd0, 3'd7, a0);
        push_exp(16'h3000, 4'd0, a0 + 7);
        send(16'h3001, 4'd1, 3'd7, a1);
        push_exp(16'h3001, 4'd1, a1 + 7);
        send(16'h3002, 4'd2, 3'd7, a2);
        push_exp(16'h3002, 4'd2, a2 + 7);
        send(16'h3003, 4'd3, 3'd7, a3);
        push_exp(16'h3003, 4'd3, a3 + 7);
        bus.in_vld = 1'b1;
        check_eq("t3_full_in_rdy", 32'(bus.in_rdy), 0);
        check_eq("t3_full_busy", 32'(bus.busy_cnt), 4);
        send(16'h3004, 4'd4, 3'd2, a4);
        push_exp(16'h3004, 4'd4, a4 + 2);
        check_eq("t3_fifth_accept", 32'(a4), 32'(a0 + 9));
        drain(40);

        // 4: backpressure holds slot 2 while slot 0 completes underneath
        bus.out_rdy = 1'b0;
        send(16'h4000, 4'hA, 3'd7, a0);
        send(16'h4001, 4'hB, 3'd7, a1);
        send(16'h4002, 4'hC, 3'd1, a2);
        while (cyc < a0 + 10) begin
            @(posedge clk); #1;
        end
        check_eq("t4_held_vld", 32'(bus.out_vld), 1);
        check_eq("t4_held_data", 32'(bus.out_data), 'h4002);
        check_eq("t4_held_tag", 32'(bus.out_tag), 'hC);
        check_eq("t4_busy", 32'(bus.busy_cnt), 3);
        e = cyc;
        bus.out_rdy = 1'b1;
        push_exp(16'h4002, 4'hC, e);
        push_exp(16'h4000, 4'hA, e + 1);
        push_exp(16'h4001, 4'hB, e + 2);
        drain(20);

        // 5a: four zero-delay items give four back-to-back outputs
        for (int i = 0; i < 4; i++) begin
            send(16'h5000 + 16'(i), 4'(i + 6), 3'd0, a0);
            push_exp(16'h5000 + 16'(i), 4'(i + 6), a0);
        end
        drain(20);

        // 5b: clamp on the max_delay=5 instance
        check_eq("t5_idle_vld", 32'(bus5.out_vld), 0);
        for (int k = 0; k < 2; k++) begin
            bus5.out_rdy  = 1'b1;
            bus5.in_vld   = 1'b1;
            bus5.in_delay = 3'(7 - k);
            bus5.in_data  = 16'h5A5A + 16'(k);
            bus5.in_tag   = 4'(9 + k);
            @(posedge clk); #1;
            a0 = cyc;
            bus5.in_vld = 1'b0;
            n = 0;
            @(negedge clk);
            while (bus5.out_vld !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            $display("clamp delay=%0d out at cyc %0d data=%h tag=%0d", 7 - k, cyc,
                     bus5.out_data, bus5.out_tag);
            check_eq("t5_clamp_cycle", 32'(cyc), 32'(a0 + 5));
            check_eq("t5_clamp_data", 32'(bus5.out_data), 32'(16'h5A5A + 16'(k)));
            check_eq("t5_clamp_tag", 32'(bus5.out_tag), 32'(9 + k));
            @(posedge clk); #1;
        end

        // 6: reset drops everything in flight, including the presented item
        bus.out_rdy = 1'b0;
        send(16'h6000, 4'd1, 3'd0, a0);
        send(16'h6001, 4'd2, 3'd5, a1);
        send(16'h6002, 4'd3, 3'd6, a2);
        check_eq("t6_pre_vld", 32'(bus.out_vld), 1);
        check_eq("t6_pre_data", 32'(bus.out_data), 'h6000);
        check_eq("t6_pre_busy", 32'(bus.busy_cnt), 3);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("t6_rst_vld", 32'(bus.out_vld), 0);
        check_eq("t6_rst_busy", 32'(bus.busy_cnt), 0);
        check_eq("t6_rst_in_rdy", 32'(bus.in_rdy), 1);
        bus.out_rdy = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("t6_no_ghost", 32'(sb_q.size()), 0);
        check_eq("t6_busy_end", 32'(bus.busy_cnt), 0);
        check_eq("t6_vld_end", 32'(bus.out_vld), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
